// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - shared state encoding and default parameters for down_timer
package down_timer_pkg;

    localparam int DT_WIDTH_DEFAULT        = 8;
    localparam int DT_PRESCALE_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } dt_state_t;

endpackage

// File: rtl/down_timer_tick_gen.sv
// rtl/down_timer_tick_gen.sv - prescaler producing one tick every DIV enabled cycles
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Phase counter: cleared on RUN entry, frozen while not enabled, wraps on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - programmable down-counting timer; DOWN_TIMER_PRESCALE_EN enables the tick prescaler
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH        = DT_WIDTH_DEFAULT,
    parameter int PRESCALE_DIV = DT_PRESCALE_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load_reload,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    dt_state_t        state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic             mode, mode_n;
    logic             tc_n;
    logic             done_n;
    logic             load_fire;
    logic             run_entry;
    logic             tick;

    assign busy       = (state == RUN);
    assign load_ready = (state != RUN);
    assign load_fire  = load_valid && load_ready;

    // Entry into RUN, computed without the tick so the prescaler clear has no loop through it
    always_comb begin
        run_entry = 1'b0;
        if (!load_fire && start) begin
            case (state)
                IDLE:    run_entry = (count != '0);
                HOLD:    run_entry = !stop;
                EXPIRED: run_entry = (reload != '0);
                default: run_entry = 1'b0;
            endcase
        end
    end

`ifdef DOWN_TIMER_PRESCALE_EN
    tick_gen #(
        .DIV(PRESCALE_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (run_entry),
        .enable (busy),
        .tick   (tick)
    );
`else
    // Legal dividers are >= 1, so without the prescaler every RUN cycle is a tick
    assign tick = (PRESCALE_DIV > 0);
`endif

    // Next-state and next-register values; a load always takes priority over start
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        mode_n   = mode;
        tc_n     = 1'b0;
        done_n   = done;
        if (load_fire) begin
            count_n  = load_value;
            reload_n = load_value;
            mode_n   = load_reload;
            state_n  = IDLE;
            done_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_entry) state_n = RUN;
                end
                RUN: begin
                    if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count_n = count - 1'b1;
                        end else if (count == WIDTH'(1)) begin
                            tc_n = 1'b1;
                            if (mode) begin
                                count_n = reload;
                            end else begin
                                count_n = '0;
                                state_n = EXPIRED;
                                done_n  = 1'b1;
                            end
                        end
                    end
                    // A one-shot expiry in the same cycle beats the pause
                    if (stop && (state_n == RUN)) state_n = HOLD;
                end
                HOLD: begin
                    if (run_entry) state_n = RUN;
                end
                EXPIRED: begin
                    if (run_entry) begin
                        count_n = reload;
                        state_n = RUN;
                        done_n  = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            reload   <= '0;
            mode     <= 1'b0;
            tc_pulse <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            reload   <= reload_n;
            mode     <= mode_n;
            tc_pulse <= tc_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - directed scoreboard bench for down_timer
module tb_down_timer;
    import down_timer_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_value = '0;
    logic         load_reload = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         tc_pulse;
    logic         done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] count;
        logic         tc;
        logic         done;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];

    down_timer #(.WIDTH(W), .PRESCALE_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .load_reload (load_reload),
        .start       (start),
        .stop        (stop),
        .count       (count),
        .busy        (busy),
        .tc_pulse    (tc_pulse),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".count"}, 32'(count), 32'(e.count));
        chk({tag, ".tc"}, 32'(tc_pulse), 32'(e.tc));
        chk({tag, ".done"}, 32'(done), 32'(e.done));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".ready"}, 32'(load_ready), 32'(!e.busy));
    endtask

    // Drive one cycle of stimulus, push the expected post-edge outputs, then pop and compare
    task automatic step(input string tag, input logic lv, input logic [W-1:0] lval,
                        input logic lrl, input logic st, input logic sp,
                        input logic [W-1:0] ec, input logic etc, input logic edn,
                        input logic eb);
        exp_t e;
        load_valid  = lv;
        load_value  = lval;
        load_reload = lrl;
        start       = st;
        stop        = sp;
        exp_q.push_back('{count: ec, tc: etc, done: edn, busy: eb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_all(tag, e);
        load_valid = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic idle(input string tag, input logic [W-1:0] ec, input logic etc,
                        input logic edn, input logic eb);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, ec, etc, edn, eb);
    endtask

    initial begin
        exp_t rst_e;
        rst_e = '{count: '0, tc: 1'b0, done: 1'b0, busy: 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", rst_e);
        rst_n = 1'b1;

`ifdef DOWN_TIMER_PRESCALE_EN
        step("ps_load", 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        step("ps_start", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            if (i < 4)       idle("ps_wait1", 8'd2, 1'b0, 1'b0, 1'b1);
            else if (i == 4) idle("ps_dec1", 8'd1, 1'b0, 1'b0, 1'b1);
            else if (i < 8)  idle("ps_wait2", 8'd1, 1'b0, 1'b0, 1'b1);
            else             idle("ps_tc", 8'd0, 1'b1, 1'b1, 1'b0);
        end
        idle("ps_after", 8'd0, 1'b0, 1'b1, 1'b0);
`else
        // One-shot of period 5
        step("os_load", 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
        step("os_start", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1);
        for (int v = 4; v >= 1; v--) idle("os_count", W'(v), 1'b0, 1'b0, 1'b1);
        idle("os_tc", 8'd0, 1'b1, 1'b1, 1'b0);
        idle("os_expired", 8'd0, 1'b0, 1'b1, 1'b0);

        // Restart from EXPIRED reloads the period, then stop pauses with the tick still applied
        step("exp_restart", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1);
        step("run_stop", 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);

        // Auto-reload of period 3 over four periods
        step("ar_load", 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        step("ar_start", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (k % 3 == 0) idle("ar_tc", 8'd3, 1'b1, 1'b0, 1'b1);
            else            idle("ar_count", W'(3 - (k % 3)), 1'b0, 1'b0, 1'b1);
        end
        step("ar_stop", 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);

        // Pause and resume
        step("pr_load", 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
        step("pr_start", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b1);
        for (int v = 9; v >= 7; v--) idle("pr_count", W'(v), 1'b0, 1'b0, 1'b1);
        step("pr_stop", 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle("pr_hold", 8'd6, 1'b0, 1'b0, 1'b0);
        step("pr_both", 1'b0, '0, 1'b0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
        step("pr_resume", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd6, 1'b0, 1'b0, 1'b1);
        idle("pr_first", 8'd5, 1'b0, 1'b0, 1'b1);
        step("run_noload", 1'b1, 8'd99, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b1);
        step("pr_stop2", 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);

        // Load beats start; start at zero count is ignored
        step("zero_load", 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step("zero_start", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Period 1 auto-reload strobes every cycle
        step("p1_load", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        step("p1_start", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle("p1_tc", 8'd1, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-RUN
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst_now", rst_e);
        @(posedge clk);
        #1;
        chk_all("arst_hold", rst_e);
        rst_n = 1'b1;

        // Maximum period one-shot
        step("max_load", 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0);
        step("max_start", 1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1);
        for (int v = 254; v >= 1; v--) idle("max_count", W'(v), 1'b0, 1'b0, 1'b1);
        idle("max_tc", 8'd0, 1'b1, 1'b1, 1'b0);
        step("clr_done", 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
